// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline-side and data-memory signal bundle for the hazard controller
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [4:0]       rdE;
    logic             loadE;
    logic             pc_srcE;
    logic             mem_accessM;
    logic             mem_ack;
    logic             stallF;
    logic             stallD;
    logic             stallE;
    logic             stallM;
    logic             flushD;
    logic             flushE;
    logic             flushW;
    logic             mem_req;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output rs1D, rs2D, rdE, loadE, pc_srcE, mem_accessM, mem_ack,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        input  mem_req, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1D, rs2D, rdE, loadE, pc_srcE, mem_accessM, mem_ack,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        output mem_req, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use/branch/data-memory stall and flush sequencer, perf counters under PIPE_PERF_CNT_EN
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Last legal wait count; MAX_WAIT is limited to 1..255 so it fits the 8-bit counter.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_req_q, mem_req_d;
    logic       mem_err_q, mem_err_d;

    logic in_wait;
    logic timeout;
    logic mem_stall;
    logic lw_stall;

    logic stall_fetch, stall_dec, stall_exe, stall_mem;
    logic flush_dec, flush_exe, flush_wb;

    assign in_wait   = (state_q == MEM_WAIT);
    assign timeout   = in_wait && (wait_cnt_q == WAIT_LAST) && !bus.mem_ack;
    assign mem_stall = (!in_wait && bus.mem_accessM) || (in_wait && !bus.mem_ack && !timeout);
    assign lw_stall  = bus.loadE && (bus.rdE != 5'd0) &&
                       ((bus.rdE == bus.rs1D) || (bus.rdE == bus.rs2D));

    // Hazard priority: memory stall freezes the whole pipe, then a taken branch, then load-use.
    // The branch beats load-use so the redirected PC is fetched instead of being held.
    always_comb begin
        stall_fetch = 1'b0;
        stall_dec   = 1'b0;
        stall_exe   = 1'b0;
        stall_mem   = 1'b0;
        flush_dec   = 1'b0;
        flush_exe   = 1'b0;
        flush_wb    = 1'b0;
        if (!reset) begin
            if (mem_stall) begin
                stall_fetch = 1'b1;
                stall_dec   = 1'b1;
                stall_exe   = 1'b1;
                stall_mem   = 1'b1;
                flush_wb    = 1'b1;
            end else if (bus.pc_srcE) begin
                flush_dec = 1'b1;
                flush_exe = 1'b1;
            end else if (lw_stall) begin
                stall_fetch = 1'b1;
                stall_dec   = 1'b1;
                flush_exe   = 1'b1;
            end
        end
    end

    // Next state of the memory handshake; the request mirrors the waiting state one cycle later.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_req_d  = mem_req_q;
        mem_err_d  = mem_err_q | timeout;
        case (state_q)
            RUN: begin
                wait_cnt_d = 8'd0;
                mem_req_d  = 1'b0;
                if (bus.mem_accessM) begin
                    state_d   = MEM_WAIT;
                    mem_req_d = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ack || timeout) begin
                    state_d    = RUN;
                    mem_req_d  = 1'b0;
                    wait_cnt_d = 8'd0;
                end else begin
                    mem_req_d  = 1'b1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = RUN;
                mem_req_d  = 1'b0;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Handshake state with its registered request and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            mem_req_q  <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_req_q  <= mem_req_d;
            mem_err_q  <= mem_err_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters so a long run never wraps back to a misleading small value.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_fetch && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_exe && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = {CNT_W{1'b0}};
    assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

    assign bus.stallF  = stall_fetch;
    assign bus.stallD  = stall_dec;
    assign bus.stallE  = stall_exe;
    assign bus.stallM  = stall_mem;
    assign bus.flushD  = flush_dec;
    assign bus.flushE  = flush_exe;
    assign bus.flushW  = flush_wb;
    assign bus.mem_req = mem_req_q;
    assign bus.mem_err = mem_err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 32;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output vector order: {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    localparam logic [6:0] V_IDLE = 7'b0000000;
    localparam logic [6:0] V_MEM  = 7'b1111001;
    localparam logic [6:0] V_BR   = 7'b0000110;
    localparam logic [6:0] V_LW   = 7'b1100010;

    logic clk = 1'b0;
    logic reset;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(
        .MAX_WAIT(MAX_WAIT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4:0] r1;
        logic [4:0] r2;
        logic [4:0] rd;
        logic       ld;
        logic       pc;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] out_vec();
        return {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.flushD, bus.flushE, bus.flushW};
    endfunction

    task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic ld, input logic pc, input logic acc, input logic ack);
        bus.rs1D        = r1;
        bus.rs2D        = r2;
        bus.rdE         = rd;
        bus.loadE       = ld;
        bus.pc_srcE     = pc;
        bus.mem_accessM = acc;
        bus.mem_ack     = ack;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    // One memory-handshake step: apply, check outputs mid-cycle, advance.
    task automatic mem_step(input string name, input logic acc, input logic ack,
                            input logic [6:0] exp_vec, input logic exp_req, input logic exp_err);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, acc, ack);
        @(negedge clk);
        chk({name, "_vec"}, 32'(out_vec()), 32'(exp_vec));
        chk({name, "_req"}, 32'(bus.mem_req), 32'(exp_req));
        chk({name, "_err"}, 32'(bus.mem_err), 32'(exp_err));
        next_cycle();
    endtask

    // Reference model state: whether an access is outstanding, how many cycles it has waited.
    bit          m_wait;
    int          m_waited;
    bit          m_err;
    logic [31:0] m_sc, m_fc;

    initial begin
        tbl[0] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, V_LW};
        tbl[1] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, V_IDLE};
        tbl[2] = '{5'd1, 5'd9, 5'd9, 1'b1, 1'b0, V_LW};
        tbl[3] = '{5'd5, 5'd6, 5'd7, 1'b1, 1'b0, V_IDLE};
        tbl[4] = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, V_IDLE};
        tbl[5] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b1, V_BR};
        tbl[6] = '{5'd3, 5'd4, 5'd8, 1'b0, 1'b1, V_BR};
        tbl[7] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b0, V_LW};

        // Reset state, with stimulus that would otherwise stall
        reset = 1'b1;
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("rst_vec", 32'(out_vec()), 32'(V_IDLE));
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_err", 32'(bus.mem_err), 32'd0);
        chk("rst_scnt", bus.stall_cnt, 32'd0);
        chk("rst_fcnt", bus.flush_cnt, 32'd0);
        next_cycle();
        reset = 1'b0;

        // Table-driven load-use / branch vectors
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].r1, tbl[i].r2, tbl[i].rd, tbl[i].ld, tbl[i].pc, 1'b0, 1'b0);
            @(negedge clk);
            chk($sformatf("table[%0d]", i), 32'(out_vec()), 32'(tbl[i].exp));
            next_cycle();
        end

        // Performance counters: 3 load-use stalls plus 2 branches
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
            next_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            next_cycle();
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("perf_stall_cnt", bus.stall_cnt, PERF ? 32'd3 : 32'd0);
        chk("perf_flush_cnt", bus.flush_cnt, PERF ? 32'd5 : 32'd0);
        next_cycle();

        // Handshake: access at cycle 0, ack at cycle 3, then back-to-back access
        do_reset();
        mem_step("hs_c0", 1'b1, 1'b0, V_MEM, 1'b0, 1'b0);
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("hs_c1_masked_vec", 32'(out_vec()), 32'(V_MEM));
        chk("hs_c1_req", 32'(bus.mem_req), 32'd1);
        next_cycle();
        mem_step("hs_c2", 1'b1, 1'b0, V_MEM, 1'b1, 1'b0);
        mem_step("hs_c3_ack", 1'b1, 1'b1, V_IDLE, 1'b1, 1'b0);
        mem_step("hs_c4_b2b", 1'b1, 1'b0, V_MEM, 1'b0, 1'b0);
        mem_step("hs_c5_ack", 1'b1, 1'b1, V_IDLE, 1'b1, 1'b0);
        mem_step("hs_c6_stray_ack", 1'b0, 1'b1, V_IDLE, 1'b0, 1'b0);
        mem_step("hs_c7_run", 1'b0, 1'b0, V_IDLE, 1'b0, 1'b0);

        // Timeout with MAX_WAIT=4: four MEM_WAIT cycles, release on the fourth
        do_reset();
        mem_step("to_c0", 1'b1, 1'b0, V_MEM, 1'b0, 1'b0);
        mem_step("to_c1", 1'b1, 1'b0, V_MEM, 1'b1, 1'b0);
        mem_step("to_c2", 1'b1, 1'b0, V_MEM, 1'b1, 1'b0);
        mem_step("to_c3", 1'b1, 1'b0, V_MEM, 1'b1, 1'b0);
        mem_step("to_c4_release", 1'b1, 1'b0, V_IDLE, 1'b1, 1'b0);
        mem_step("to_c5_err", 1'b0, 1'b0, V_IDLE, 1'b0, 1'b1);
        mem_step("to_c6_acc", 1'b1, 1'b0, V_MEM, 1'b0, 1'b1);
        mem_step("to_c7_ack", 1'b1, 1'b1, V_IDLE, 1'b1, 1'b1);
        mem_step("to_c8_sticky", 1'b0, 1'b0, V_IDLE, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a wait
        mem_step("ar_c0", 1'b1, 1'b0, V_MEM, 1'b0, 1'b1);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("ar_req_before", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("ar_req_async", 32'(bus.mem_req), 32'd0);
        chk("ar_err_async", 32'(bus.mem_err), 32'd0);
        chk("ar_vec_async", 32'(out_vec()), 32'(V_IDLE));
        next_cycle();
        reset = 1'b0;
        mem_step("ar_run_idle", 1'b0, 1'b0, V_IDLE, 1'b0, 1'b0);
        mem_step("ar_run_acc", 1'b1, 1'b0, V_MEM, 1'b0, 1'b0);

        // Randomized traffic against the reference model
        do_reset();
        m_wait   = 1'b0;
        m_waited = 0;
        m_err    = 1'b0;
        m_sc     = 32'd0;
        m_fc     = 32'd0;
        for (int n = 0; n < 400; n++) begin
            logic [4:0] r1, r2, rd;
            logic       ld, pc, acc, ack, tmo, mst, lw;
            logic [6:0] exp;
            r1  = 5'($urandom_range(0, 3));
            r2  = 5'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 3));
            ld  = 1'($urandom_range(0, 1));
            pc  = ($urandom_range(0, 5) == 0);
            acc = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 4) == 0);
            drive(r1, r2, rd, ld, pc, acc, ack);
            @(negedge clk);

            // An outstanding access is abandoned once it has waited MAX_WAIT cycles without ack.
            tmo = m_wait && (m_waited + 1 >= MAX_WAIT) && !ack;
            mst = m_wait ? (!ack && !tmo) : acc;
            lw  = ld && (rd != 0) && (rd == r1 || rd == r2);
            exp = mst ? V_MEM : (pc ? V_BR : (lw ? V_LW : V_IDLE));

            chk("rnd_vec", 32'(out_vec()), 32'(exp));
            chk("rnd_req", 32'(bus.mem_req), 32'(m_wait));
            chk("rnd_err", 32'(bus.mem_err), 32'(m_err));
            chk("rnd_scnt", bus.stall_cnt, PERF ? m_sc : 32'd0);
            chk("rnd_fcnt", bus.flush_cnt, PERF ? m_fc : 32'd0);

            if (exp[6] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 32'd1;
            if (exp[1] && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 32'd1;
            if (m_wait) begin
                if (ack || tmo) begin
                    m_wait   = 1'b0;
                    m_waited = 0;
                    if (tmo) m_err = 1'b1;
                end else begin
                    m_waited = m_waited + 1;
                end
            end else if (acc) begin
                m_wait   = 1'b1;
                m_waited = 0;
            end
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
